// File: rtl/store_trace_if.sv
// Store-trace bundle: M-stage store capture in, valid/ready trace port out.
// trc_ts exists only when STORE_TRACE_TS_EN is defined.
interface store_trace_if #(
  parameter int DEPTH  = 8,
  parameter int DROP_W = 16,
  parameter int TS_W   = 32
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic              MemWriteM;
  logic [63:0]       ALUResultM;
  logic [63:0]       WriteDataM;
  logic              clear;
  logic              trc_valid;
  logic              trc_ready;
  logic [60:0]       trc_addr;
  logic [63:0]       trc_data;
  logic [CW-1:0]     trc_count;
  logic              trc_overflow;
  logic [DROP_W-1:0] trc_drop_cnt;
`ifdef STORE_TRACE_TS_EN
  logic [TS_W-1:0]   trc_ts;
`else
  wire  [TS_W-1:0]   unused_ts = '0;
`endif

  modport master (
    output MemWriteM, ALUResultM, WriteDataM,
    output clear, trc_ready,
`ifdef STORE_TRACE_TS_EN
    input  trc_ts,
`endif
    input  trc_valid, trc_addr, trc_data,
    input  trc_count, trc_overflow, trc_drop_cnt
  );

  modport slave (
    input  MemWriteM, ALUResultM, WriteDataM,
    input  clear, trc_ready,
`ifdef STORE_TRACE_TS_EN
    output trc_ts,
`endif
    output trc_valid, trc_addr, trc_data,
    output trc_count, trc_overflow, trc_drop_cnt
  );
endinterface

// File: rtl/store_trace_buffer.sv
// In-order FWFT FIFO of M-stage stores with loss counting.
// Define STORE_TRACE_TS_EN to tag each entry with a capture-cycle timestamp.
module store_trace_buffer #(
  parameter int DEPTH  = 8,
  parameter int DROP_W = 16,
  parameter int TS_W   = 32
) (
  input logic         clk,
  input logic         rst,
  store_trace_if.slave s
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic [AW-1:0]     wr_idx;
  logic [AW-1:0]     rd_idx;
  logic [60:0]       addr_mem [DEPTH];
  logic [63:0]       data_mem [DEPTH];
  logic              overflow;
  logic [DROP_W-1:0] drop_cnt;
  logic              empty;
  logic              full;
  logic              pop;
  logic              push;
  logic              drop;
  logic              wr_en;
  logic              unused_lo;

  assign wr_idx = wr_ptr[AW-1:0];
  assign rd_idx = rd_ptr[AW-1:0];
  assign empty  = (wr_ptr == rd_ptr);
  assign full   = (wr_ptr[AW] != rd_ptr[AW])
               && (wr_idx == rd_idx);
  assign pop    = !empty && s.trc_ready;
  assign push   = s.MemWriteM && (!full || pop);
  assign drop   = s.MemWriteM && full && !pop;
  assign wr_en  = push && !rst && !s.clear;

  // low address bits select a byte within the word and are not traced
  assign unused_lo = ^s.ALUResultM[2:0];

  always_ff @(posedge clk) begin
    if (rst || s.clear) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)
        rd_ptr <= rd_ptr + (AW+1)'(1);
      if (drop) begin
        overflow <= 1'b1;
        if (drop_cnt != '1)
          drop_cnt <= drop_cnt + DROP_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      addr_mem[wr_idx] <= s.ALUResultM[63:3];
      data_mem[wr_idx] <= s.WriteDataM;
    end
  end

`ifdef STORE_TRACE_TS_EN
  logic [TS_W-1:0] ts;
  logic [TS_W-1:0] ts_mem [DEPTH];

  // free-running; clear deliberately leaves it alone
  always_ff @(posedge clk) begin
    if (rst)
      ts <= '0;
    else
      ts <= ts + TS_W'(1);
  end

  always_ff @(posedge clk) begin
    if (wr_en)
      ts_mem[wr_idx] <= ts;
  end

  assign s.trc_ts = ts_mem[rd_idx];
`endif

  assign s.trc_valid    = !empty;
  assign s.trc_addr     = addr_mem[rd_idx];
  assign s.trc_data     = data_mem[rd_idx];
  assign s.trc_count    = wr_ptr - rd_ptr;
  assign s.trc_overflow = overflow;
  assign s.trc_drop_cnt = drop_cnt;
endmodule

// File: tb/tb_store_trace_buffer.sv
// Scoreboard bench for store_trace_buffer: queue-based reference model,
// directed scenarios followed by randomized traffic with clears and resets.
module tb_store_trace_buffer;
  localparam int DEPTH    = 8;
  localparam int DROP_W   = 3;
  localparam int TS_W     = 32;
  localparam int DROP_MAX = (1 << DROP_W) - 1;

  typedef struct {
    logic [60:0] a;
    logic [63:0] d;
    logic [31:0] t;
  } ent_t;

  logic clk;
  logic rst;

  store_trace_if #(
    .DEPTH(DEPTH), .DROP_W(DROP_W), .TS_W(TS_W)
  ) s ();

  store_trace_buffer #(
    .DEPTH(DEPTH), .DROP_W(DROP_W), .TS_W(TS_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .s(s)
  );

  ent_t    exp_q [$];
  int      mdl_n;
  bit      mdl_ovf;
  int      mdl_drop;
  longint unsigned mdl_ts;
  int      n_chk;
  int      n_fail;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  // Reference model: applied right after each edge, to the inputs
  // that edge sampled (still held on the bus).
  task automatic model();
    ent_t e;
    if (rst) begin
      mdl_n = 0;
      exp_q.delete();
      mdl_ovf = 0;
      mdl_drop = 0;
      mdl_ts = 0;
    end else begin
      if (s.clear) begin
        mdl_n = 0;
        exp_q.delete();
        mdl_ovf = 0;
        mdl_drop = 0;
      end else begin
        if (mdl_n > 0 && s.trc_ready)
          mdl_n--;
        if (s.MemWriteM) begin
          if (mdl_n < DEPTH) begin
            e.a = s.ALUResultM[63:3];
            e.d = s.WriteDataM;
            e.t = mdl_ts[31:0];
            exp_q.push_back(e);
            mdl_n++;
          end else begin
            mdl_ovf = 1;
            if (mdl_drop < DROP_MAX)
              mdl_drop++;
          end
        end
      end
      mdl_ts++;
    end
  endtask

  task automatic step(input logic m,
                      input logic [63:0] a,
                      input logic [63:0] d,
                      input logic rd,
                      input logic cl,
                      input logic r);
    s.MemWriteM  = m;
    s.ALUResultM = a;
    s.WriteDataM = d;
    s.trc_ready  = rd;
    s.clear      = cl;
    rst          = r;
    @(posedge clk);
    #1;
    model();
  endtask

  task automatic idle(input logic rd);
    step(1'b0, 64'h0, 64'h0, rd, 1'b0, 1'b0);
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  // Monitor: state checks every cycle, head compared on each pop.
  always @(negedge clk) begin
    ent_t e;
    if (!rst) begin
      chk("valid", 64'(s.trc_valid), 64'(mdl_n != 0));
      chk("count", 64'(s.trc_count), 64'(mdl_n));
      chk("overflow", 64'(s.trc_overflow), 64'(mdl_ovf));
      chk("drop_cnt", 64'(s.trc_drop_cnt), 64'(mdl_drop));
      if (s.trc_valid && s.trc_ready && !s.clear) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL pop: got unexpected entry data %0h",
                   s.trc_data);
        end else begin
          e = exp_q.pop_front();
          chk("addr", 64'(s.trc_addr), 64'(e.a));
          chk("data", s.trc_data, e.d);
`ifdef STORE_TRACE_TS_EN
          chk("ts", 64'(s.trc_ts), 64'(e.t));
`endif
        end
      end
    end
  end

  initial begin
    int bias;
    n_chk  = 0;
    n_fail = 0;
    mdl_n  = 0;
    mdl_ovf = 0;
    mdl_drop = 0;
    mdl_ts = 0;
    s.MemWriteM  = 1'b0;
    s.ALUResultM = '0;
    s.WriteDataM = '0;
    s.trc_ready  = 1'b0;
    s.clear      = 1'b0;
    rst          = 1'b1;

    repeat (3) step(1'b1, rnd64(), rnd64(), 1'b1, 1'b0, 1'b1);
    repeat (3) idle(1'b0);

    step(1'b1, 64'h40, 64'd5, 1'b1, 1'b0, 1'b0);
    repeat (3) idle(1'b1);

    for (int i = 1; i <= 10; i++)
      step(1'b1, rnd64(), 64'(i), 1'b0, 1'b0, 1'b0);
    repeat (2) idle(1'b0);
    repeat (10) idle(1'b1);

    for (int i = 0; i < DEPTH; i++)
      step(1'b1, rnd64(), 64'(100 + i), 1'b0, 1'b0, 1'b0);
    step(1'b1, rnd64(), 64'd200, 1'b1, 1'b0, 1'b0);
    idle(1'b0);
    repeat (10) idle(1'b1);

    for (int i = 0; i < 20; i++)
      step(1'b1, rnd64(), rnd64(), 1'($urandom % 2),
           1'b0, 1'b0);
    repeat (12) idle(1'b1);
    for (int i = 0; i < 5; i++)
      step(1'b1, rnd64(), rnd64(), 1'b0, 1'b0, 1'b0);
    step(1'b1, rnd64(), rnd64(), 1'b1, 1'b1, 1'b0);
    repeat (3) idle(1'b1);

    bias = 2;
    for (int i = 0; i < 4000; i++) begin
      if (i % 200 == 0)
        bias = int'($urandom_range(0, 4));
      step(1'($urandom % 4 != 0), rnd64(), rnd64(),
           1'(int'($urandom % 4) < bias),
           1'($urandom % 150 == 0),
           1'($urandom % 700 == 0));
    end
    repeat (12) idle(1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
